uart_tx_arbiter: RTL and testbench

Round-robin controller that shares one uart_tx serializer among N_REQ byte-stream requesters. Typical requesters are counter- or FIFO-fed sources like those in top_fifo_uart.
- Grants one requester at a time, for a burst of up to MAX_BURST bytes.
- Optionally prefixes each burst with a channel-ID header byte.
- Paces every byte against the serializer's busy flag.
- Sits between the requester FIFOs and the uart_tx instance in the top level.

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the uart_tx arbiter slice.
package uart_arb_pkg;

  // Arbiter sequencing states; IDLE must encode as zero.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DRAIN = 3'd5
  } arb_state_e;

  // Channel-ID header base; the requester index lands in the low bits.
  localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hA0;

  // Index width for n requesters (never narrower than one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Burst counter width able to hold the value max_burst itself.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Circular priority encoder: first asserted request at or after the pointer.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // cand[k] is the requester index k steps after the pointer, wrapped at N.
  logic [IDX_W-1:0] cand [N];
  logic [N-1:0]     hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      // Wrap is explicit so non-power-of-two N never aliases onto a bogus index.
      assign sum       = {1'b0, i_ptr} + (IDX_W + 1)'(gi);
      assign cand[gi]  = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N))
                                                  : IDX_W'(sum);
      assign hit[gi]   = i_req[cand[gi]];
    end
  endgenerate

  // Scan from farthest to nearest so the smallest offset wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        o_found = 1'b1;
        o_idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a single uart_tx serializer shared by N_REQ byte sources.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         N_REQ       = 4,
  parameter int         WIDTH       = 8,
  parameter int         MAX_BURST   = 16,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BASE = HEADER_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic [N_REQ-1:0]       o_grant,
  output logic [WIDTH-1:0]       o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy,
  output logic                   o_busy
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = cnt_w(MAX_BURST);

  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);
  localparam logic [WIDTH-1:0] HDR_BASE_W = WIDTH'(HEADER_BASE);

  arb_state_e       state_q,     state_d;
  logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [WIDTH-1:0] tx_data_q,   tx_data_d;
  logic [N_REQ-1:0] grant_q,     grant_d;
  logic             hdr_last_q,  hdr_last_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [WIDTH-1:0] req_bytes [N_REQ];
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic [IDX_W-1:0] ptr_after_idx;
  logic [WIDTH-1:0] header_byte;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (rr_ptr_q),
    .o_found (pick_found),
    .o_idx   (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_bytes[gi] = i_req_data[gi*WIDTH +: WIDTH];
      // Only the owner sees ready, and only while LOAD samples its byte;
      // held low during reset so nothing is consumed by an aborted transfer.
      assign o_req_ready[gi] = !i_reset && (state_q == ST_LOAD) &&
                               (idx_q == IDX_W'(gi)) && i_req_valid[gi];
    end
  endgenerate

  assign sel_data      = req_bytes[idx_q];
  assign sel_valid     = i_req_valid[idx_q];
  assign ptr_after_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign header_byte   = HDR_BASE_W | WIDTH'(idx_q);

  assign o_grant    = grant_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = (state_q == ST_ISSUE);
  assign o_busy     = (state_q != ST_IDLE);

  // Next-state and next-output decode for the grant/pacing sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    burst_cnt_d = burst_cnt_q;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    hdr_last_d  = hdr_last_q;

    case (state_q)
      ST_IDLE: begin
        if (i_enable && pick_found) begin
          idx_d       = pick_idx;
          grant_d     = N_REQ'(1) << pick_idx;
          burst_cnt_d = '0;
          hdr_last_d  = 1'b0;
          state_d     = (HEADER_EN != 0) ? ST_HDR : ST_LOAD;
        end
      end

      ST_HDR: begin
        tx_data_d  = header_byte;
        hdr_last_d = 1'b1;
        state_d    = ST_ISSUE;
      end

      ST_LOAD: begin
        if (sel_valid) begin
          tx_data_d   = sel_data;
          burst_cnt_d = (burst_cnt_q == MAX_CNT) ? burst_cnt_q : burst_cnt_q + 1'b1;
          hdr_last_d  = 1'b0;
          state_d     = ST_ISSUE;
        end else begin
          // Source ran dry: give the serializer up without sending anything.
          grant_d  = '0;
          rr_ptr_d = ptr_after_idx;
          state_d  = ST_IDLE;
        end
      end

      ST_ISSUE: state_d = ST_GAP;

      // Serializer busy is not yet valid here; just let it rise.
      ST_GAP:   state_d = ST_DRAIN;

      ST_DRAIN: begin
        if (!i_tx_busy) begin
          if (hdr_last_q) begin
            state_d = ST_LOAD;
          end else if ((burst_cnt_q == MAX_CNT) || !i_enable) begin
            grant_d  = '0;
            rr_ptr_d = ptr_after_idx;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset overrides any in-flight transfer.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      burst_cnt_q <= '0;
      tx_data_q   <= '0;
      grant_q     <= '0;
      hdr_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      burst_cnt_q <= burst_cnt_d;
      tx_data_q   <= tx_data_d;
      grant_q     <= grant_d;
      hdr_last_q  <= hdr_last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: queue-level arbitration model vs. bytes seen at the serializer.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_enable = 1'b0;
  logic [N-1:0]   i_req_valid = '0;
  logic [N*W-1:0] i_req_data = '0;
  logic           i_tx_busy = 1'b0;
  logic [N-1:0]   o_req_ready;
  logic [N-1:0]   o_grant;
  logic [W-1:0]   o_tx_data;
  logic           o_tx_start;
  logic           o_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .WIDTH       (W),
    .MAX_BURST   (MB),
    .HEADER_EN   (1),
    .HEADER_BASE (8'hA0)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_busy   (i_tx_busy),
    .o_busy      (o_busy)
  );

  // Requester FIFOs, expected rx stream, expected (owner, data bytes) per grant.
  logic [7:0] src_q [N][$];
  logic [7:0] exp_q [$];
  int         exp_burst_idx [$];
  int         exp_burst_len [$];

  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  int start_cnt = 0;
  int busy_cnt = 0;
  int ncyc = 0;
  int last_start = -100;
  int ready_cnt = 0;
  logic [N-1:0] pend_pop = '0;
  logic [N-1:0] prev_grant = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: serve current FIFO contents round-robin, header then up to MB bytes.
  task automatic model_drain();
    logic [7:0] cp [N][$];
    int found, n;
    for (int k = 0; k < N; k++) cp[k] = src_q[k];
    forever begin
      found = -1;
      for (int off = 0; off < N; off++) begin
        if (found < 0 && cp[(m_ptr + off) % N].size() != 0) found = (m_ptr + off) % N;
      end
      if (found < 0) break;
      exp_q.push_back(8'hA0 | 8'(found));
      n = 0;
      while (n < MB && cp[found].size() != 0) begin
        exp_q.push_back(cp[found].pop_front());
        n++;
      end
      exp_burst_idx.push_back(found);
      exp_burst_len.push_back(n);
      m_ptr = (found + 1) % N;
    end
  endtask

  task automatic fill_rand(input int k, input int n);
    for (int i = 0; i < n; i++) src_q[k].push_back(8'($urandom));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((!all_empty() || o_busy || i_tx_busy || exp_q.size() != 0) && n < 4000);
    check({name, "_done_in_time"}, 32'(n < 4000), 32'd1);
    @(negedge clk); #1;
    check({name, "_grant_idle"}, 32'(o_grant), 32'd0);
    check({name, "_busy_idle"}, 32'(o_busy), 32'd0);
    check({name, "_rx_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_bursts_left"}, 32'(exp_burst_idx.size()), 32'd0);
  endtask

  // Monitor + serializer model + requester FIFO driver, all away from the active edge.
  always @(negedge clk) begin
    logic [7:0]   e;
    logic [N-1:0] new_pop;
    int           gidx;
    ncyc++;
    new_pop = '0;
    if (i_reset) begin
      busy_cnt   = 0;
      i_tx_busy  = 1'b0;
      prev_grant = '0;
      ready_cnt  = 0;
      last_start = -100;
    end else begin
      check("grant_onehot_or_zero", 32'($countones(o_grant) <= 1), 32'd1);
      check("ready_outside_grant", 32'(o_req_ready & ~o_grant), 32'd0);
      if (o_tx_start) begin
        check("start_while_busy", 32'(i_tx_busy), 32'd0);
        check("start_spacing", 32'((ncyc - last_start) >= 3), 32'd1);
        last_start = ncyc;
        start_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got 0x%h, want no byte", o_tx_data);
        end else begin
          e = exp_q.pop_front();
          $display("rx byte 0x%h (expected 0x%h)", o_tx_data, e);
          check("rx_byte", 32'(o_tx_data), 32'(e));
        end
        busy_cnt  = $urandom_range(8, 2);
        i_tx_busy = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        i_tx_busy = (busy_cnt > 0);
      end
      new_pop   = o_req_ready & i_req_valid;
      ready_cnt += $countones(o_req_ready);
      if (prev_grant != '0 && o_grant != prev_grant) begin
        check("grant_through_zero", 32'(o_grant), 32'd0);
        gidx = 0;
        for (int k = 0; k < N; k++) if (prev_grant[k]) gidx = k;
        $display("grant %0d released after %0d data bytes", gidx, ready_cnt);
        if (exp_burst_idx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL burst_unexpected: got grant %0d, want none", gidx);
        end else begin
          check("burst_owner", 32'(gidx), 32'(exp_burst_idx.pop_front()));
          check("burst_ready_count", 32'(ready_cnt), 32'(exp_burst_len.pop_front()));
        end
        ready_cnt = 0;
      end
      prev_grant = o_grant;
    end
    // Bytes acknowledged at the previous edge leave their FIFO now.
    for (int k = 0; k < N; k++) begin
      if (pend_pop[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
    end
    pend_pop = new_pop;
    for (int k = 0; k < N; k++) begin
      i_req_valid[k]       = (src_q[k].size() != 0);
      i_req_data[k*W +: W] = (src_q[k].size() != 0) ? src_q[k][0] : 8'h00;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int n, base;
    repeat (3) @(posedge clk);
    #2;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_start", 32'(o_tx_start), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    i_reset  = 1'b0;
    i_enable = 1'b1;

    // Single source, three bytes, then empty.
    src_q[0] = '{8'h11, 8'h22, 8'h33};
    model_drain();
    wait_idle("t1");

    // Two always-busy sources exercise full-length bursts and alternation.
    @(posedge clk); #2;
    fill_rand(0, 9);
    fill_rand(1, 9);
    model_drain();
    wait_idle("t2");

    // Pointer rotation: after req2, req3 outranks req0.
    @(posedge clk); #2;
    fill_rand(2, 2);
    model_drain();
    wait_idle("t3a");
    @(posedge clk); #2;
    fill_rand(0, 3);
    fill_rand(3, 3);
    model_drain();
    n = 0;
    do begin @(posedge clk); #2; n++; end while (o_grant == '0 && n < 100);
    check("t3_first_grant", 32'(o_grant), 32'h8);
    wait_idle("t3b");

    // Enable falls during req1's second data byte.
    @(posedge clk); #2;
    fill_rand(1, 5);
    exp_q.push_back(8'hA1);
    exp_q.push_back(src_q[1][0]);
    exp_q.push_back(src_q[1][1]);
    exp_burst_idx.push_back(1);
    exp_burst_len.push_back(2);
    m_ptr = 2;
    base = start_cnt;
    n = 0;
    while (start_cnt < base + 3 && n < 1000) begin @(posedge clk); #2; n++; end
    check("t4_third_start_seen", 32'(n < 1000), 32'd1);
    i_enable = 1'b0;
    n = 0;
    while (o_busy && n < 1000) begin @(posedge clk); #2; n++; end
    check("t4_release_seen", 32'(n < 1000), 32'd1);
    repeat (20) @(posedge clk);
    #2;
    check("t4_no_extra_rx", 32'(exp_q.size()), 32'd0);
    check("t4_bytes_left", 32'(src_q[1].size()), 32'd3);
    check("t4_grant_idle", 32'(o_grant), 32'd0);
    check("t4_no_start", 32'(o_tx_start), 32'd0);
    fill_rand(2, 3);
    model_drain();
    i_enable = 1'b1;
    wait_idle("t4");

    // Reset while the serializer drains req2's first data byte.
    @(posedge clk); #2;
    fill_rand(2, 3);
    exp_q.push_back(8'hA2);
    exp_q.push_back(src_q[2][0]);
    base = start_cnt;
    n = 0;
    while (start_cnt < base + 2 && n < 1000) begin @(posedge clk); #2; n++; end
    check("t5_data_start_seen", 32'(n < 1000), 32'd1);
    @(posedge clk); #2;
    check("t5_busy_in_drain", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    @(posedge clk); #2;
    check("t5_rst_grant", 32'(o_grant), 32'd0);
    check("t5_rst_start", 32'(o_tx_start), 32'd0);
    check("t5_rst_busy", 32'(o_busy), 32'd0);
    check("t5_rst_ready", 32'(o_req_ready), 32'd0);
    check("t5_rst_tx_data", 32'(o_tx_data), 32'd0);
    check("t5_rx_complete", 32'(exp_q.size()), 32'd0);
    i_reset = 1'b0;
    m_ptr = 0;
    fill_rand(1, 2);
    model_drain();
    n = 0;
    do begin @(posedge clk); #2; n++; end while (o_grant == '0 && n < 100);
    check("t5_first_grant_lowest", 32'(o_grant), 32'h2);
    wait_idle("t5");

    // Random FIFO loads.
    for (int r = 0; r < 12; r++) begin
      @(posedge clk); #2;
      for (int k = 0; k < N; k++) begin
        n = $urandom_range(9, 0);
        if ($urandom_range(3, 0) == 0) n = 0;
        fill_rand(k, n);
      end
      model_drain();
      wait_idle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
